// File: rtl/wb_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_ctrl
// Purpose  : Write-back controller in front of the register bank. It buffers
//            tagged ALU results in a small FIFO and retires one entry per
//            cycle as a registered data bus plus a one-hot write enable. It
//            also exports a pending-write mask for RAW hazard stalls.
// Options  : WB_R0_ZERO_EN - register 0 is hard-wired zero. Writes to it
//            still occupy a slot and a pop cycle, but never raise an enable.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_dest,
    input  logic [DATA_W-1:0]          in_data,
    output logic [DATA_W-1:0]          alu_bus,
    output logic [NREG-1:0]            reg_enable,
    output logic [NREG-1:0]            pending,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // FIFO storage; contents need no reset because occupancy tracks validity
    logic [ADDR_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    logic              head_is_r0;
    logic [NREG-1:0]   buffered_mask;

    assign head_dest = dest_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

`ifdef WB_R0_ZERO_EN
    // Writes to the zero register are swallowed at the output stage
    assign head_is_r0 = (head_dest == '0);
`else
    assign head_is_r0 = 1'b0;
`endif

    // Acceptance depends only on occupancy, never on the same-cycle pop
    assign in_ready = reset && !flush && (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = reset && !flush && (count != '0);

    // Capture accepted results at the tail of the FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem[wr_ptr] <= in_dest;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and the registered output stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            alu_bus    <= '0;
            reg_enable <= '0;
        end else if (flush) begin
            // The bank still captures whatever was presented this cycle
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            reg_enable <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (head_is_r0) begin
                    reg_enable <= '0;
                end else begin
                    alu_bus    <= head_data;
                    reg_enable <= NREG'(1) << head_dest;
                end
            end else begin
                reg_enable <= '0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // OR together the destinations of every occupied FIFO slot
    always_comb begin
        buffered_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Distance of slot i from the head, modulo DEPTH
            if (CNT_W'(PTR_W'(i) - rd_ptr) < count) begin
                buffered_mask = buffered_mask | (NREG'(1) << dest_mem[i]);
            end
        end
    end

    // Hazard mask: buffered writes plus the one on the output stage
    always_comb begin
        pending = '0;
        if (reset) begin
            pending = buffered_mask | reg_enable;
        end
`ifdef WB_R0_ZERO_EN
        pending[0] = 1'b0;
`endif
    end

endmodule
`default_nettype wire
